// File: rtl/rmt_axil_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out,
// with a per-phase watchdog and saturating transaction statistics.
module rmt_axil_master #(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'h44020000,
  parameter int          C_TIMEOUT          = 256
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [31:0]                     cmd_addr,
  input  logic [31:0]                     cmd_wdata,
  input  logic [3:0]                      cmd_wstrb,

  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,

  output logic [15:0]                     stat_wr_cnt,
  output logic [15:0]                     stat_rd_cnt,
  output logic [15:0]                     stat_err_cnt
);

  localparam int          STRB_W   = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                      state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic                            wr_q, wr_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            arvalid_q, arvalid_d;
  logic [15:0]                     timer_q, timer_d;
  logic [31:0]                     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;
  logic                            rsp_timeout_q, rsp_timeout_d;
  logic [15:0]                     stat_wr_q, stat_wr_d;
  logic [15:0]                     stat_rd_q, stat_rd_d;
  logic [15:0]                     stat_err_q, stat_err_d;

  logic tmo_hit;
  logic phase_fail;
  logic aw_ok;
  logic w_ok;
  logic in_phase;

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    stat_wr_d     = stat_wr_q;
    stat_rd_d     = stat_rd_q;
    stat_err_d    = stat_err_q;
    phase_fail    = 1'b0;
    tmo_hit       = (timer_q == TMO_LAST);
    aw_ok         = !awvalid_q || M_AXI_AWREADY;
    w_ok          = !wvalid_q || M_AXI_WREADY;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d    = cmd_wr;
          addr_d  = C_M_AXI_ADDR_WIDTH'(C_BASEADDR ^ cmd_addr);
          wdata_d = C_M_AXI_DATA_WIDTH'(cmd_wdata);
          wstrb_d = STRB_W'(cmd_wstrb);
          if (cmd_wr) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
        if (aw_ok && w_ok) state_d = S_WR_RESP;
        else if (tmo_hit)  phase_fail = 1'b1;
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          rsp_resp_d    = M_AXI_BRESP;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = S_DONE;
        end else if (tmo_hit) begin
          phase_fail = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_RESP;
        end else if (tmo_hit) begin
          phase_fail = 1'b1;
        end
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rsp_rdata_d   = 32'(M_AXI_RDATA);
          rsp_resp_d    = M_AXI_RRESP;
          rsp_timeout_d = 1'b0;
          state_d       = S_DONE;
        end else if (tmo_hit) begin
          phase_fail = 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if (wr_q) begin
            if (stat_wr_q != 16'hFFFF) stat_wr_d = stat_wr_q + 16'd1;
          end else begin
            if (stat_rd_q != 16'hFFFF) stat_rd_d = stat_rd_q + 16'd1;
          end
          if ((rsp_resp_q != 2'b00 || rsp_timeout_q) && stat_err_q != 16'hFFFF)
            stat_err_d = stat_err_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A watchdog expiry abandons the phase and reports SLVERR with the timeout flag.
    if (phase_fail) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
      state_d       = S_DONE;
    end

    in_phase = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
               (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
    if (state_d != state_q) timer_d = '0;
    else if (in_phase)      timer_d = timer_q + 16'd1;
    else                    timer_d = '0;

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      timer_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      stat_wr_q     <= '0;
      stat_rd_q     <= '0;
      stat_err_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      timer_q       <= timer_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      stat_wr_q     <= stat_wr_d;
      stat_rd_q     <= stat_rd_d;
      stat_err_q    <= stat_err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = (state_q == S_DONE);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_RREADY  = (state_q == S_RD_RESP);
  assign stat_wr_cnt   = stat_wr_q;
  assign stat_rd_cnt   = stat_rd_q;
  assign stat_err_cnt  = stat_err_q;

endmodule

// File: tb/tb_rmt_axil_master.sv
// Scoreboard bench for rmt_axil_master: a randomized AXI-Lite slave follows a
// per-command delay plan, and expected responses come from the timeout rules.
module tb_rmt_axil_master;

  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h44020000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;

  always #5 clk = ~clk;

  rmt_axil_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(32),
    .C_BASEADDR(BASE),
    .C_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_wr = 0, m_rd = 0, m_err = 0;

  int          p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0, p_hold = 0;
  logic [1:0]  p_bresp = 2'b00, p_rresp = 2'b00;
  logic [31:0] p_rdata = '0, e_addr = '0, e_wdata = '0;
  logic [3:0]  e_wstrb = '0;

  // Cycles a valid/ready stays high: one past the handshake cycle, or the whole watchdog window.
  function automatic int dur(input int d);
    return (d <= TMO - 1) ? d + 1 : TMO;
  endfunction

  function automatic int rnd_delay();
    return ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int aw, input int w, input int b,
                               input logic [1:0] bresp, input int ar, input int r,
                               input logic [31:0] rdata, input logic [1:0] rresp, input int hold);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'(1));
      return;
    end
    p_aw = aw; p_w = w; p_b = b; p_ar = ar; p_r = r; p_hold = hold;
    p_bresp = bresp; p_rresp = rresp; p_rdata = rdata;
    e_addr = BASE ^ addr; e_wdata = wdata; e_wstrb = wstrb;
    e.wr = wr; e.rdata = '0; e.resp = 2'b00; e.tmo = 1'b0;
    if (wr) begin
      if (aw > TMO - 1 || w > TMO - 1 || b > TMO - 1) e.tmo = 1'b1;
      else e.resp = bresp;
    end else begin
      if (ar > TMO - 1 || r > TMO - 1) e.tmo = 1'b1;
      else begin
        e.rdata = rdata;
        e.resp  = rresp;
      end
    end
    if (e.tmo) e.resp = 2'b10;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_wr = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
  endtask

  // Write address channel slave
  initial begin
    int cnt;
    cnt = 0;
    M_AXI_AWREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (M_AXI_AWVALID) begin
        M_AXI_AWREADY = (cnt == p_aw);
        if (cnt == p_aw) checkOutput("awaddr", M_AXI_AWADDR, e_addr);
        cnt++;
      end else begin
        if (cnt > 0 && !reset) checkOutput("awvalid_len", 32'(cnt), 32'(dur(p_aw)));
        M_AXI_AWREADY = 1'b0;
        cnt = 0;
      end
    end
  end

  // Write data channel slave
  initial begin
    int cnt;
    cnt = 0;
    M_AXI_WREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (M_AXI_WVALID) begin
        M_AXI_WREADY = (cnt == p_w);
        if (cnt == p_w) begin
          checkOutput("wdata", M_AXI_WDATA, e_wdata);
          checkOutput("wstrb", 32'(M_AXI_WSTRB), 32'(e_wstrb));
        end
        cnt++;
      end else begin
        if (cnt > 0 && !reset) checkOutput("wvalid_len", 32'(cnt), 32'(dur(p_w)));
        M_AXI_WREADY = 1'b0;
        cnt = 0;
      end
    end
  end

  // Read address channel slave
  initial begin
    int cnt;
    cnt = 0;
    M_AXI_ARREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (M_AXI_ARVALID) begin
        M_AXI_ARREADY = (cnt == p_ar);
        if (cnt == p_ar) checkOutput("araddr", M_AXI_ARADDR, e_addr);
        cnt++;
      end else begin
        if (cnt > 0 && !reset) checkOutput("arvalid_len", 32'(cnt), 32'(dur(p_ar)));
        M_AXI_ARREADY = 1'b0;
        cnt = 0;
      end
    end
  end

  // Write response slave; junk BVALID while BREADY is low must be ignored
  initial begin
    int cnt;
    cnt = 0;
    M_AXI_BVALID = 1'b0;
    M_AXI_BRESP  = 2'b00;
    forever begin
      @(negedge clk);
      if (M_AXI_BREADY) begin
        M_AXI_BVALID = (cnt >= p_b);
        M_AXI_BRESP  = (cnt >= p_b) ? p_bresp : 2'b11;
        cnt++;
      end else begin
        if (cnt > 0 && !reset) checkOutput("bready_len", 32'(cnt), 32'(dur(p_b)));
        cnt = 0;
        M_AXI_BVALID = ($urandom_range(0, 3) == 0);
        M_AXI_BRESP  = 2'b11;
      end
    end
  end

  // Read data slave; junk RVALID while RREADY is low must be ignored
  initial begin
    int cnt;
    cnt = 0;
    M_AXI_RVALID = 1'b0;
    M_AXI_RRESP  = 2'b00;
    M_AXI_RDATA  = '0;
    forever begin
      @(negedge clk);
      if (M_AXI_RREADY) begin
        M_AXI_RVALID = (cnt >= p_r);
        M_AXI_RRESP  = (cnt >= p_r) ? p_rresp : 2'b11;
        M_AXI_RDATA  = (cnt >= p_r) ? p_rdata : $urandom;
        cnt++;
      end else begin
        if (cnt > 0 && !reset) checkOutput("rready_len", 32'(cnt), 32'(dur(p_r)));
        cnt = 0;
        M_AXI_RVALID = ($urandom_range(0, 3) == 0);
        M_AXI_RRESP  = 2'b11;
        M_AXI_RDATA  = $urandom;
      end
    end
  end

  // Response monitor: compares every presented response cycle against the queue head
  initial begin
    int   vcnt;
    bit   stat_chk;
    exp_t e;
    vcnt = 0;
    stat_chk = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stat_chk) begin
        checkOutput("stat_wr_cnt", 32'(stat_wr_cnt), 32'(m_wr));
        checkOutput("stat_rd_cnt", 32'(stat_rd_cnt), 32'(m_rd));
        checkOutput("stat_err_cnt", 32'(stat_err_cnt), 32'(m_err));
        checkOutput("cmd_ready_after_done", 32'(cmd_ready), 32'(1));
        stat_chk = 1'b0;
      end
      if (rsp_valid && !reset) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(rsp_valid), 32'(0));
          rsp_ready = 1'b1;
        end else begin
          e = exp_q[0];
          checkOutput("rsp_rdata", rsp_rdata, e.rdata);
          checkOutput("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
          checkOutput("cmd_ready_in_done", 32'(cmd_ready), 32'(0));
          rsp_ready = (vcnt >= p_hold);
          if (vcnt >= p_hold) begin
            void'(exp_q.pop_front());
            if (e.wr) m_wr++;
            else m_rd++;
            if (e.resp != 2'b00 || e.tmo) m_err++;
            stat_chk = 1'b1;
          end
          vcnt++;
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
        vcnt = 0;
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_resp", 32'({rsp_resp, rsp_timeout}), 32'(0));
    checkOutput("rst_axi_handshake",
                32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}), 32'(0));
    checkOutput("rst_awaddr", M_AXI_AWADDR, 32'h0);
    checkOutput("rst_araddr", M_AXI_ARADDR, 32'h0);
    checkOutput("rst_wdata", M_AXI_WDATA, 32'h0);
    checkOutput("rst_wstrb", 32'(M_AXI_WSTRB), 32'(0));
    checkOutput("rst_stats", 32'(stat_wr_cnt | stat_rd_cnt | stat_err_cnt), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'(1));

    applyStimulus(1'b1, 32'h4, 32'h0000_00FF, 4'hF, 0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 3, 32'h1234_5678, 2'b00, 0);
    applyStimulus(1'b1, 32'h10, 32'hA5A5_0001, 4'h3, 4, 0, 1, 2'b00, 0, 0, 32'h0, 2'b00, 1);
    applyStimulus(1'b0, 32'hC, 32'h0, 4'h0, 0, 0, 0, 2'b00, 100, 0, 32'hDEAD_BEEF, 2'b00, 0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1, 2, 32'hCAFE_F00D, 2'b10, 5);
    applyStimulus(1'b1, 32'h24, 32'h1357_9BDF, 4'h9, 15, 15, 15, 2'b01, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(1'b1, 32'h28, 32'h2468_ACE0, 4'hC, 3, 16, 0, 2'b00, 0, 0, 32'h0, 2'b00, 2);
    applyStimulus(1'b1, 32'h2C, 32'h0F0F_0F0F, 4'hF, 0, 2, 16, 2'b00, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 2'b00, 15, 15, 32'h5555_AAAA, 2'b00, 0);
    applyStimulus(1'b0, 32'h34, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2, 16, 32'h7777_8888, 2'b00, 1);

    // Reset while the write response is still outstanding
    applyStimulus(1'b1, 32'h38, 32'h0000_0001, 4'hF, 0, 0, 12, 2'b00, 0, 0, 32'h0, 2'b00, 0);
    waited = 0;
    while (!M_AXI_BREADY && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reach_wr_resp", 32'(M_AXI_BREADY), 32'(1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    m_wr = 0; m_rd = 0; m_err = 0;
    @(negedge clk);
    checkOutput("rst_mid_bready", 32'(M_AXI_BREADY), 32'(0));
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_mid_cmd_ready", 32'(cmd_ready), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_cmd_ready_rel", 32'(cmd_ready), 32'(1));
    checkOutput("rst_mid_stat_wr", 32'(stat_wr_cnt), 32'(0));
    checkOutput("rst_mid_stat_rd", 32'(stat_rd_cnt), 32'(0));
    checkOutput("rst_mid_stat_err", 32'(stat_err_cnt), 32'(0));

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    rnd_delay(), rnd_delay(), rnd_delay(), 2'($urandom),
                    rnd_delay(), rnd_delay(), $urandom, 2'($urandom),
                    int'($urandom_range(0, 3)));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);
    checkOutput("final_stat_wr", 32'(stat_wr_cnt), 32'(m_wr));
    checkOutput("final_stat_rd", 32'(stat_rd_cnt), 32'(m_rd));
    checkOutput("final_stat_err", 32'(stat_err_cnt), 32'(m_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
